// File: rtl/mig_ui_pkg.sv
// Shared constants for the MIG UI native-interface responder: command
// encodings, default widths and the queue depth.
package mig_ui_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } app_cmd_e;

  localparam int MIG_DATA_W        = 128;
  localparam int MIG_ADDR_W        = 28;
  localparam int MEM_DEPTH_LOG2    = 10;
  localparam int ADDR_WORD_SHIFT   = 3;
  localparam int CALIB_DELAY       = 64;
  localparam int READ_LATENCY      = 8;
  localparam int RDY_STALL_PERIOD  = 0;
  localparam int QUEUE_DEPTH       = 4;

  // Only plain writes and reads are executed; everything else is flagged.
  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/mig_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. DEPTH must
// be a power of two and at least 2. Push into a full FIFO or pop from an
// empty one is ignored.
module mig_resp_fifo
  import mig_ui_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  // NOTE: no reset here; contents are only meaningful under count_q, and an
  // unreset array maps onto RAM primitives instead of flops.
  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mig_native_responder.sv
// BRAM-backed responder for the MIG UI native interface (4:1 rate, one beat
// per command). Commands and write beats are queued independently and paired
// in order at the head of the command queue; reads return through a fixed
// Read_Latency pipeline.
module mig_native_responder
  import mig_ui_pkg::*;
#(
  parameter int MIG_Data_Port_Size = MIG_DATA_W,
  parameter int MIG_Addr_Port_Size = MIG_ADDR_W,
  parameter int Mem_Depth_Log2     = MEM_DEPTH_LOG2,
  parameter int Addr_Word_Shift    = ADDR_WORD_SHIFT,
  parameter int Calib_Delay        = CALIB_DELAY,
  parameter int Read_Latency       = READ_LATENCY,
  parameter int Rdy_Stall_Period   = RDY_STALL_PERIOD,
  parameter int Queue_Depth        = QUEUE_DEPTH
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  output logic                          init_calib,
  input  logic [MIG_Addr_Port_Size-1:0] app_addr,
  input  logic [2:0]                    app_cmd,
  input  logic                          app_en,
  output logic                          app_rdy,
  input  logic [MIG_Data_Port_Size-1:0] app_wdf_data,
  input  logic                          app_wdf_wren,
  input  logic                          app_wdf_end,
  output logic                          app_wdf_rdy,
  output logic [MIG_Data_Port_Size-1:0] app_rd_data,
  output logic                          app_rd_data_valid,
  output logic                          app_rd_data_end,
  output logic                          err_cmd,
  output logic                          err_addr,
  output logic                          err_wdf
);

  localparam int IDX_W     = Mem_Depth_Log2;
  localparam int MEM_WORDS = 1 << Mem_Depth_Log2;
  localparam int CMD_W     = 3 + IDX_W;
  localparam int QCNT_W    = $clog2(Queue_Depth) + 1;
  localparam int CAL_W     = (Calib_Delay > 0) ? $clog2(Calib_Delay + 1) : 1;

  logic [CAL_W-1:0]              calib_cnt_q, calib_cnt_d;
  logic                          init_calib_q, init_calib_d;
  logic                          err_cmd_q, err_cmd_d;
  logic                          err_addr_q, err_addr_d;
  logic                          err_wdf_q, err_wdf_d;
  logic                          stall;
  logic                          cmd_accept, wdf_accept;
  logic [MIG_Addr_Port_Size-1:0] shifted_addr;
  logic [IDX_W-1:0]              word_idx;
  logic                          addr_oob;
  logic [CMD_W-1:0]              cmd_head;
  logic [2:0]                    head_cmd;
  logic [IDX_W-1:0]              head_idx;
  logic [MIG_Data_Port_Size-1:0] wdf_head;
  logic                          cmd_full, cmd_empty, wdf_full, wdf_empty;
  logic [QCNT_W-1:0]             cmd_count, wdf_count;
  logic                          unused_counts;
  logic                          cmd_pop, wdf_pop, ram_we, rd_launch;
  logic [MIG_Data_Port_Size-1:0] ram_q [MEM_WORDS];
  logic [Read_Latency-1:0]       rd_valid_q;
  logic [MIG_Data_Port_Size-1:0] rd_data_q [Read_Latency];

  // Handshakes depend only on registered state, never on app_en/app_wdf_wren.
  assign app_rdy     = init_calib_q & ~cmd_full & ~stall;
  assign app_wdf_rdy = init_calib_q & ~wdf_full;
  assign cmd_accept  = app_en & app_rdy;
  assign wdf_accept  = app_wdf_wren & app_wdf_rdy;

  // Word index wraps to the RAM depth; dropped upper bits are reported.
  assign shifted_addr = app_addr >> Addr_Word_Shift;
  assign word_idx     = shifted_addr[IDX_W-1:0];
  assign addr_oob     = |(shifted_addr >> IDX_W);

  assign head_cmd = cmd_head[CMD_W-1 -: 3];
  assign head_idx = cmd_head[IDX_W-1:0];

  // Occupancy counts are not needed here; fold them into a sink.
  assign unused_counts = ^{cmd_count, wdf_count};

  generate
    if (Rdy_Stall_Period == 0) begin : g_no_stall
      assign stall = 1'b0;
    end else begin : g_stall
      localparam int STALL_W = (Rdy_Stall_Period > 1) ? $clog2(Rdy_Stall_Period) : 1;
      logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
      assign stall       = (stall_cnt_q == STALL_W'(Rdy_Stall_Period - 1));
      assign stall_cnt_d = stall ? '0 : stall_cnt_q + STALL_W'(1);
      // Free-running stall counter, wraps at the stall period.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
      end
    end
  endgenerate

  mig_resp_fifo #(.WIDTH(CMD_W), .DEPTH(Queue_Depth)) u_cmd_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (cmd_accept),
    .wdata_i ({app_cmd, word_idx}),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  mig_resp_fifo #(.WIDTH(MIG_Data_Port_Size), .DEPTH(Queue_Depth)) u_wdf_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (wdf_accept),
    .wdata_i (app_wdf_data),
    .pop_i   (wdf_pop),
    .rdata_o (wdf_head),
    .full_o  (wdf_full),
    .empty_o (wdf_empty),
    .count_o (wdf_count)
  );

  // Execute the head command: writes wait for a beat, reads and illegal
  // commands retire immediately.
  always_comb begin
    cmd_pop   = 1'b0;
    wdf_pop   = 1'b0;
    ram_we    = 1'b0;
    rd_launch = 1'b0;
    if (!cmd_empty) begin
      if (head_cmd == CMD_WRITE) begin
        if (!wdf_empty) begin
          cmd_pop = 1'b1;
          wdf_pop = 1'b1;
          ram_we  = 1'b1;
        end
      end else if (head_cmd == CMD_READ) begin
        cmd_pop   = 1'b1;
        rd_launch = 1'b1;
      end else begin
        cmd_pop = 1'b1;
      end
    end
  end

  // Backing RAM write port.
  always_ff @(posedge aclk) begin
    if (ram_we) ram_q[head_idx] <= wdf_head;
  end

  // Read return pipeline; data stages are cleared so app_rd_data is 0 after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_valid_q <= '0;
      for (int i = 0; i < Read_Latency; i++) rd_data_q[i] <= '0;
    end else begin
      rd_valid_q[0] <= rd_launch;
      if (rd_launch) rd_data_q[0] <= ram_q[head_idx];
      for (int i = 1; i < Read_Latency; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  assign app_rd_data       = rd_data_q[Read_Latency-1];
  assign app_rd_data_valid = rd_valid_q[Read_Latency-1];
  assign app_rd_data_end   = rd_valid_q[Read_Latency-1];

  // Calibration countdown and sticky error flags.
  always_comb begin
    calib_cnt_d  = calib_cnt_q;
    init_calib_d = init_calib_q;
    if (!init_calib_q) begin
      calib_cnt_d = calib_cnt_q + CAL_W'(1);
      if (calib_cnt_d >= CAL_W'(Calib_Delay)) init_calib_d = 1'b1;
    end
    err_cmd_d  = err_cmd_q  | (cmd_accept & ~cmd_is_legal(app_cmd));
    err_addr_d = err_addr_q | (cmd_accept & addr_oob);
    err_wdf_d  = err_wdf_q  | (wdf_accept & (app_wdf_end != app_wdf_wren));
  end

  // Calibration and error registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      calib_cnt_q  <= '0;
      init_calib_q <= 1'b0;
      err_cmd_q    <= 1'b0;
      err_addr_q   <= 1'b0;
      err_wdf_q    <= 1'b0;
    end else begin
      calib_cnt_q  <= calib_cnt_d;
      init_calib_q <= init_calib_d;
      err_cmd_q    <= err_cmd_d;
      err_addr_q   <= err_addr_d;
      err_wdf_q    <= err_wdf_d;
    end
  end

  assign init_calib = init_calib_q;
  assign err_cmd    = err_cmd_q;
  assign err_addr   = err_addr_q;
  assign err_wdf    = err_wdf_q;

endmodule

// File: tb/tb_mig_native_responder.sv
// Scenario bench for mig_native_responder: a reference memory model pairs
// write beats with write commands in order, read acceptances push expected
// data to a scoreboard, and a negedge monitor pops and compares returns.
module tb_mig_native_responder;
  import mig_ui_pkg::*;

  localparam int DW     = 128;
  localparam int AW     = 28;
  localparam int SHIFT  = 3;
  localparam int DLOG2  = 10;
  localparam int CALIB  = 64;
  localparam int RLAT   = 8;
  localparam int QD     = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          init_calib;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          err_cmd, err_addr, err_wdf;

  int checks = 0;
  int errors = 0;
  int rd_seen = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] beat_q[$];
  int            widx_q[$];
  logic [DW-1:0] model_mem[int];

  localparam logic [DW-1:0] DA5 = {16{8'hA5}};
  localparam logic [DW-1:0] D0  = {4{32'h0D0D_0000}};
  localparam logic [DW-1:0] D1  = {4{32'h0D0D_1111}};

  mig_native_responder #(
    .MIG_Data_Port_Size (DW),
    .MIG_Addr_Port_Size (AW),
    .Mem_Depth_Log2     (DLOG2),
    .Addr_Word_Shift    (SHIFT),
    .Calib_Delay        (CALIB),
    .Read_Latency       (RLAT),
    .Rdy_Stall_Period   (0),
    .Queue_Depth        (QD)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .init_calib        (init_calib),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .err_cmd           (err_cmd),
    .err_addr          (err_addr),
    .err_wdf           (err_wdf)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  function automatic int word_of(input logic [AW-1:0] a);
    int w;
    w = int'(a >> SHIFT);
    return w % (1 << DLOG2);
  endfunction

  task automatic pair_model();
    while (beat_q.size() > 0 && widx_q.size() > 0)
      model_mem[widx_q.pop_front()] = beat_q.pop_front();
  endtask

  // Scoreboard monitor: every returned beat must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn && app_rd_data_valid) begin
      logic [DW-1:0] exp;
      rd_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got data %h with no read outstanding", app_rd_data);
      end else begin
        exp = exp_q.pop_front();
        if (app_rd_data !== exp || app_rd_data_end !== 1'b1) begin
          errors++;
          $display("FAIL rd_data: got %h end=%b, required %h end=1", app_rd_data, app_rd_data_end, exp);
        end
      end
    end
  end

  // Present one command at a negedge; returns at the negedge after acceptance.
  task automatic issue_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    int n;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr; n = 0;
    while (app_rdy !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
    checks++;
    if (app_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout: app_rdy=%b required 1", app_rdy);
      app_en = 1'b0;
      return;
    end
    @(posedge aclk);
    if (cmd == CMD_WRITE) begin
      widx_q.push_back(word_of(addr));
      pair_model();
    end else if (cmd == CMD_READ) begin
      exp_q.push_back(model_mem[word_of(addr)]);
    end
    @(negedge aclk);
    app_en = 1'b0;
  endtask

  task automatic issue_beat(input logic [DW-1:0] data, input logic last);
    int n;
    app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_end = last; n = 0;
    while (app_wdf_rdy !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
    checks++;
    if (app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wdf_accept_timeout: app_wdf_rdy=%b required 1", app_wdf_rdy);
      app_wdf_wren = 1'b0;
      return;
    end
    @(posedge aclk);
    beat_q.push_back(data);
    pair_model();
    @(negedge aclk);
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(negedge aclk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
  endtask

  // Called at a negedge with aresetn just released.
  task automatic check_calibration();
    int first_bad;
    first_bad = 0;
    for (int i = 1; i <= CALIB; i++) begin
      @(posedge aclk); #1;
      if (i < CALIB && (init_calib !== 1'b0 || app_rdy !== 1'b0) && first_bad == 0) first_bad = i;
    end
    checks++;
    if (first_bad != 0) begin
      errors++;
      $display("FAIL calib_low: init_calib/app_rdy high at cycle %0d, required low before %0d", first_bad, CALIB);
    end
    checks++;
    if (init_calib !== 1'b1 || app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL calib_high: init_calib=%b app_rdy=%b app_wdf_rdy=%b at cycle %0d, required 1 1 1",
               init_calib, app_rdy, app_wdf_rdy, CALIB);
    end
    @(negedge aclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({init_calib, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
         err_cmd, err_addr, err_wdf} !== 8'h00 || app_rd_data !== '0) begin
      errors++;
      $display("FAIL %s: ctl=%b%b%b%b%b err=%b%b%b data=%h, required all 0",
               tag, init_calib, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
               err_cmd, err_addr, err_wdf, app_rd_data);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset_values");
    aresetn = 1'b1;
    check_calibration();
  endtask

  task automatic test_write_read_latency();
    int k;
    issue_beat(DA5, 1'b1);
    issue_cmd(CMD_WRITE, 28'h08);
    repeat (3) @(negedge aclk);
    issue_cmd(CMD_READ, 28'h08);
    k = 1;
    while (app_rd_data_valid !== 1'b1 && k < 40) begin @(negedge aclk); k++; end
    checks++;
    if (k != RLAT + 1) begin
      errors++;
      $display("FAIL read_latency: valid in cycle %0d, required %0d", k, RLAT + 1);
    end
    drain();
  endtask

  task automatic test_data_before_cmd();
    issue_beat(D0, 1'b1);
    issue_beat(D1, 1'b1);
    issue_cmd(CMD_WRITE, 28'h00);
    issue_cmd(CMD_WRITE, 28'h08);
    issue_cmd(CMD_READ, 28'h08);
    issue_cmd(CMD_READ, 28'h00);
    drain();
  endtask

  task automatic test_cmd_queue_full();
    int n;
    for (int i = 0; i < QD; i++) issue_cmd(CMD_WRITE, AW'(28'h10 + 8 * i));
    checks++;
    if (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_full: app_rdy=%b app_wdf_rdy=%b, required 0 1", app_rdy, app_wdf_rdy);
    end
    issue_beat({4{32'hB000_0000}}, 1'b1);
    n = 0;
    while (app_rdy !== 1'b1 && n < 3) begin @(negedge aclk); n++; end
    checks++;
    if (app_rdy !== 1'b1 || n > 1) begin
      errors++;
      $display("FAIL rdy_return: app_rdy=%b after %0d cycles, required 1 within 1", app_rdy, n);
    end
    issue_cmd(CMD_WRITE, 28'h30);
    for (int i = 1; i <= QD; i++) issue_beat({4{32'hB000_0000 + i}}, 1'b1);
    repeat (4) @(negedge aclk);
    issue_cmd(CMD_READ, 28'h30);
    issue_cmd(CMD_READ, 28'h18);
    issue_cmd(CMD_READ, 28'h10);
    drain();
  endtask

  task automatic test_errors();
    int seen_before;
    checks++;
    if ({err_cmd, err_addr, err_wdf} !== 3'b000) begin
      errors++;
      $display("FAIL err_clear: err=%b%b%b, required 000", err_cmd, err_addr, err_wdf);
    end
    seen_before = rd_seen;
    issue_cmd(3'b011, 28'h08);
    repeat (RLAT + 6) @(negedge aclk);
    checks++;
    if (err_cmd !== 1'b1 || err_addr !== 1'b0 || rd_seen != seen_before) begin
      errors++;
      $display("FAIL err_cmd: err_cmd=%b err_addr=%b returns=%0d, required 1 0 0",
               err_cmd, err_addr, rd_seen - seen_before);
    end
    issue_cmd(CMD_READ, 28'h4000);
    checks++;
    if (err_addr !== 1'b1) begin
      errors++;
      $display("FAIL err_addr: err_addr=%b, required 1", err_addr);
    end
    drain();
    issue_beat({4{32'hBAD0_BEEF}}, 1'b0);
    checks++;
    if (err_wdf !== 1'b1 || err_cmd !== 1'b1) begin
      errors++;
      $display("FAIL err_wdf: err_wdf=%b err_cmd=%b, required 1 1", err_wdf, err_cmd);
    end
  endtask

  task automatic test_reset_midflight();
    int seen_before;
    issue_cmd(CMD_READ, 28'h00);
    issue_cmd(CMD_READ, 28'h08);
    issue_cmd(CMD_READ, 28'h10);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("reset_midflight");
    exp_q.delete();
    beat_q.delete();
    widx_q.delete();
    seen_before = rd_seen;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    check_calibration();
    repeat (RLAT + 10) @(negedge aclk);
    checks++;
    if (rd_seen != seen_before) begin
      errors++;
      $display("FAIL flush: %0d reads returned after reset, required 0", rd_seen - seen_before);
    end
    issue_cmd(CMD_READ, 28'h08);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read_latency();
    test_data_before_cmd();
    test_cmd_queue_full();
    test_errors();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
